// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_pkg
//   Shared definitions for the fetch/data SRAM port arbiter.
//   - state_t     : FSM state encoding (3 bits)
//   - GNT_IF/MEM  : port identifiers, also used as indices into per-port vectors
//   - SRAM_IDLE   : inactive level of the active-low SRAM control strobes
// -----------------------------------------------------------------------------
package sram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  localparam int   NUM_PORTS = 2;
  localparam logic GNT_IF    = 1'b0;
  localparam logic GNT_MEM   = 1'b1;

  // OE/WE/EN are active-low, so "idle" is logic high.
  localparam logic SRAM_IDLE = 1'b1;

  // The data bus is driven by us for the whole write envelope
  // (setup, pulse and hold), never during reads or idle.
  function automatic logic is_write_state(input state_t s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_tristate_drv.sv
// -----------------------------------------------------------------------------
// sram_tristate_drv
//   16-bit bidirectional SRAM data-bus driver with a registered output enable
//   and registered write data, plus one read-capture register per port.
//
//   clk        in    system clock
//   rst_n      in    asynchronous active-low reset (releases the bus at once)
//   drive_next in    drive enable for the next cycle
//   load_wdata in    load wdata_next into the write-data register
//   wdata_next in    write data to present on the bus
//   cap_en     in    per-port capture strobe; samples ram_data at the edge
//   cap_data   out   per-port captured read data (holds until next capture)
//   ram_data   inout SRAM data bus
// -----------------------------------------------------------------------------
module sram_tristate_drv
  import sram_port_arbiter_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        drive_next,
  input  logic                        load_wdata,
  input  logic [15:0]                 wdata_next,
  input  logic [NUM_PORTS-1:0]        cap_en,
  output logic [NUM_PORTS-1:0][15:0]  cap_data,
  inout  wire  [15:0]                 ram_data
);

  logic        drive_reg;
  logic [15:0] wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_reg <= 1'b0;
      wdata_reg <= '0;
    end else begin
      drive_reg <= drive_next;
      if (load_wdata) begin
        wdata_reg <= wdata_next;
      end
    end
  end

  assign ram_data = drive_reg ? wdata_reg : 16'hzzzz;

  // Separate holding register per port so a data read never disturbs the
  // last fetched word and vice versa.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cap
      logic [15:0] cap_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cap_reg <= '0;
        end else if (cap_en[gi]) begin
          cap_reg <= ram_data;
        end
      end
      assign cap_data[gi] = cap_reg;
    end
  endgenerate

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one asynchronous 16-bit SRAM between the instruction-fetch port and
//   the MEM-stage data port. A small FSM sequences read (2-cycle) and write
//   (3+WR_PULSE cycle) timing; ties are broken by alternating grants.
//
//   Parameters
//     ADDR_HI   upper two bits of ramAddr
//     WR_PULSE  cycles WE is held low during a write (1..3)
//
//   Ports
//     CLK, RST               clock, asynchronous active-low reset
//     if_req/if_addr         fetch request and address
//     if_rdata/if_ready      fetched word and one-cycle completion pulse
//     mem_rd/mem_wr          data read / write request (write wins)
//     mem_addr/mem_wdata     data address and write data
//     mem_rdata/mem_ready    read data and one-cycle completion pulse
//     stall                  combinational pipeline freeze
//     ramOE/ramWE/ramEN      active-low SRAM strobes (registered)
//     ramAddr                {ADDR_HI, granted address} (registered)
//     ramData                SRAM data bus, driven only while writing
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter logic [1:0] ADDR_HI  = 2'b00,
  parameter int         WR_PULSE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall,
  output logic        ramOE,
  output logic        ramWE,
  output logic        ramEN,
  output logic [17:0] ramAddr,
  inout  wire  [15:0] ramData
);

  state_t                    state_reg, state_next;
  logic                      last_grant_reg, last_grant_next;
  logic                      gnt_port_reg, gnt_port_next;
  logic [1:0]                pulse_cnt_reg, pulse_cnt_next;
  logic [17:0]               addr_reg, addr_next;
  logic                      oe_reg, we_reg, en_reg;
  logic                      oe_next, we_next, en_next;
  logic [NUM_PORTS-1:0]      ready_reg, ready_next;

  logic [NUM_PORTS-1:0]      req_vec;
  logic [NUM_PORTS-1:0]      eligible;
  logic                      grant;
  logic                      drive_next;
  logic                      load_wdata;
  logic [NUM_PORTS-1:0]      cap_en;
  logic [NUM_PORTS-1:0][15:0] cap_data;

  // ---------------------------------------------------------------------------
  // Request qualification: a port whose ready pulse is out this cycle still has
  // its request held high by the pipeline, so it must not be re-granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_vec          = '0;
    req_vec[GNT_IF]  = if_req;
    req_vec[GNT_MEM] = mem_rd | mem_wr;
  end

  assign eligible = req_vec & ~ready_reg;

  // ---------------------------------------------------------------------------
  // FSM state register and all pin-facing registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GNT_IF;
      gnt_port_reg   <= GNT_IF;
      pulse_cnt_reg  <= '0;
      addr_reg       <= '0;
      oe_reg         <= SRAM_IDLE;
      we_reg         <= SRAM_IDLE;
      en_reg         <= SRAM_IDLE;
      ready_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      gnt_port_reg   <= gnt_port_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      addr_reg       <= addr_next;
      oe_reg         <= oe_next;
      we_reg         <= we_next;
      en_reg         <= en_next;
      ready_reg      <= ready_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, arbitration and next pin levels
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    gnt_port_next   = gnt_port_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    addr_next       = addr_reg;
    ready_next      = '0;
    cap_en          = '0;
    load_wdata      = 1'b0;
    grant           = GNT_IF;

    case (state_reg)
      ST_IDLE: begin
        if (|eligible) begin
          // Data port wins unless both want the bus and it had the last turn.
          if (eligible[GNT_MEM] && !(eligible[GNT_IF] && last_grant_reg == GNT_MEM)) begin
            grant = GNT_MEM;
          end else begin
            grant = GNT_IF;
          end
          gnt_port_next   = grant;
          last_grant_next = grant;
          addr_next       = {ADDR_HI, (grant == GNT_MEM) ? mem_addr : if_addr};
          // Fetch can only ever read; for the data port a write beats a read.
          if (grant == GNT_MEM && mem_wr) begin
            load_wdata = 1'b1;
            state_next = ST_WR_SETUP;
          end else begin
            state_next = ST_RD;
          end
        end
      end

      ST_RD: begin
        // Bus is sampled on the edge that ends the single OE-low cycle.
        cap_en[gnt_port_reg]     = 1'b1;
        ready_next[gnt_port_reg] = 1'b1;
        state_next               = ST_IDLE;
      end

      ST_WR_SETUP: begin
        pulse_cnt_next = 2'(WR_PULSE - 1);
        state_next     = ST_WR_PULSE;
      end

      ST_WR_PULSE: begin
        if (pulse_cnt_reg == 2'd0) begin
          state_next = ST_WR_HOLD;
        end else begin
          pulse_cnt_next = pulse_cnt_reg - 2'd1;
        end
      end

      ST_WR_HOLD: begin
        ready_next[GNT_MEM] = 1'b1;
        state_next          = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Strobes are a pure function of the state being entered, registered so
    // the pins carry no combinational path from the request inputs.
    en_next    = (state_next == ST_IDLE)     ? SRAM_IDLE : ~SRAM_IDLE;
    oe_next    = (state_next == ST_RD)       ? ~SRAM_IDLE : SRAM_IDLE;
    we_next    = (state_next == ST_WR_PULSE) ? ~SRAM_IDLE : SRAM_IDLE;
    drive_next = is_write_state(state_next);
  end

  // ---------------------------------------------------------------------------
  // Data bus driver and read capture
  // ---------------------------------------------------------------------------
  sram_tristate_drv u_drv (
    .clk        (CLK),
    .rst_n      (RST),
    .drive_next (drive_next),
    .load_wdata (load_wdata),
    .wdata_next (mem_wdata),
    .cap_en     (cap_en),
    .cap_data   (cap_data),
    .ram_data   (ramData)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ramOE     = oe_reg;
  assign ramWE     = we_reg;
  assign ramEN     = en_reg;
  assign ramAddr   = addr_reg;
  assign if_ready  = ready_reg[GNT_IF];
  assign mem_ready = ready_reg[GNT_MEM];
  assign if_rdata  = cap_data[GNT_IF];
  assign mem_rdata = cap_data[GNT_MEM];
  assign stall     = (if_req & ~if_ready) | ((mem_rd | mem_wr) & ~mem_ready);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter with an asynchronous SRAM device model
//   and a transaction-level reference model checked on every falling edge.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int WRP = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        ramOE, ramWE, ramEN;
  logic [17:0] ramAddr;
  wire  [15:0] ramData;

  int errors = 0;
  int checks = 0;

  sram_port_arbiter #(.ADDR_HI(2'b00), .WR_PULSE(WRP)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .ramOE(ramOE), .ramWE(ramWE), .ramEN(ramEN), .ramAddr(ramAddr), .ramData(ramData)
  );

  always #5 CLK = ~CLK;

  // Released bus reads as all ones.
  pullup pu_bus (ramData);

  // ---------------- external SRAM device ----------------
  logic [15:0] dev_mem [0:65535];
  logic [15:0] mdl_mem [0:65535];

  assign ramData = (!ramEN && !ramOE && ramWE) ? dev_mem[ramAddr[15:0]] : 16'hzzzz;

  always @(posedge CLK) begin
    if (!ramEN && !ramWE) dev_mem[ramAddr[15:0]] <= ramData;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          busy = 0, acc_mem = 0, acc_write = 0, last_mem = 0;
  int          off = 0, lat = 0;
  logic [15:0] acc_addr = '0, acc_wdata = '0;
  logic [15:0] exp_if_rdata = '0, exp_mem_rdata = '0;
  bit          exp_if_rdy, exp_mem_rdy;
  logic        e_en, e_oe, e_we;
  int          obs_q [$];

  always @(negedge CLK) begin
    if (!RST) begin
      busy = 0; last_mem = 0; exp_if_rdata = '0; exp_mem_rdata = '0;
      check("rst_pins", {ramEN, ramOE, ramWE}, 3'b111);
      check("rst_bus", ramData, 16'hFFFF);
      check("rst_ready", {if_ready, mem_ready}, 2'b00);
      check("rst_rdata", {if_rdata, mem_rdata}, 32'h0);
    end else begin
      exp_if_rdy = 0; exp_mem_rdy = 0;
      e_en = 1; e_oe = 1; e_we = 1;
      if (busy) begin
        off++;
        if (off == lat) begin
          busy = 0;
          if (acc_mem) exp_mem_rdy = 1; else exp_if_rdy = 1;
          if (acc_write) mdl_mem[acc_addr] = acc_wdata;
          else if (acc_mem) exp_mem_rdata = mdl_mem[acc_addr];
          else exp_if_rdata = mdl_mem[acc_addr];
        end else begin
          e_en = 0;
          check("m_addr", ramAddr, {2'b00, acc_addr});
          if (acc_write) begin
            e_we = (off >= 2 && off <= 1 + WRP) ? 1'b0 : 1'b1;
            check("m_wbus", ramData, acc_wdata);
          end else begin
            e_oe = 0;
          end
        end
      end
      if (!busy) begin
        bit want_if, want_mem, pick_mem;
        if (off != lat || lat == 0) check("m_idle_bus", ramData, 16'hFFFF);
        want_if  = if_req && !exp_if_rdy;
        want_mem = (mem_rd || mem_wr) && !exp_mem_rdy;
        if (want_if || want_mem) begin
          pick_mem  = want_mem && (!want_if || !last_mem);
          busy      = 1; off = 0;
          acc_mem   = pick_mem;
          acc_write = pick_mem && mem_wr;
          acc_addr  = pick_mem ? mem_addr : if_addr;
          acc_wdata = mem_wdata;
          lat       = acc_write ? 3 + WRP : 2;
          last_mem  = pick_mem;
        end
      end
      check("m_pins", {ramEN, ramOE, ramWE}, {e_en, e_oe, e_we});
      check("m_ready", {if_ready, mem_ready}, {exp_if_rdy, exp_mem_rdy});
      check("m_if_rdata", if_rdata, exp_if_rdata);
      check("m_mem_rdata", mem_rdata, exp_mem_rdata);
      check("m_stall", stall, (if_req && !exp_if_rdy) || ((mem_rd || mem_wr) && !exp_mem_rdy));
      if (if_ready)  begin obs_q.push_back(0); $display("txn IF  rdata=%h t=%0t", if_rdata, $time); end
      if (mem_ready) begin obs_q.push_back(1); $display("txn MEM rdata=%h t=%0t", mem_rdata, $time); end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_rdy(input bit is_mem, input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (is_mem ? mem_ready : if_ready) return;
    end
    checks++; errors++;
    $display("FAIL %s timeout got=no_ready exp=ready", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 16'(i) ^ 16'h5A5A;
      mdl_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    dev_mem[16'h0040] = 16'hA5C3;
    mdl_mem[16'h0040] = 16'hA5C3;

    // Reset with a pending fetch
    #1 RST = 1'b0;
    if_req = 1'b1; if_addr = 16'h0010;
    repeat (3) @(negedge CLK);
    check("reset_pins", {ramEN, ramOE, ramWE}, 3'b111);
    check("reset_ready", {if_ready, mem_ready}, 2'b00);
    tick(); RST = 1'b1;
    @(negedge CLK); check("rel_c0_ready", if_ready, 1'b0);
    @(negedge CLK); check("rel_c1_oe", ramOE, 1'b0);
    @(negedge CLK); check("rel_c2_ready", if_ready, 1'b1);
    check("rel_c2_rdata", if_rdata, 16'h5A4A);
    tick(); if_req = 1'b0;

    // Data write
    tick(); mem_wr = 1'b1; mem_addr = 16'h8001; mem_wdata = 16'h1234;
    @(negedge CLK); check("wr_c0_we", ramWE, 1'b1);
    @(negedge CLK); check("wr_setup", {ramEN, ramOE, ramWE}, 3'b011);
    check("wr_setup_ad", {ramAddr, ramData}, {18'h08001, 16'h1234});
    @(negedge CLK); check("wr_pulse", {ramEN, ramOE, ramWE}, 3'b010);
    check("wr_pulse_ad", {ramAddr, ramData}, {18'h08001, 16'h1234});
    @(negedge CLK); check("wr_hold", {ramEN, ramOE, ramWE, ramData}, {3'b011, 16'h1234});
    @(negedge CLK); check("wr_ready", mem_ready, 1'b1);
    tick(); mem_wr = 1'b0;
    tick(); check("wr_devmem", dev_mem[16'h8001], 16'h1234);

    // Fetch read
    tick(); if_req = 1'b1; if_addr = 16'h0040;
    @(negedge CLK); check("rd_c0_oe", ramOE, 1'b1);
    @(negedge CLK); check("rd_c1_addr", ramAddr, 18'h00040);
    check("rd_c1_oe", ramOE, 1'b0);
    @(negedge CLK); check("rd_c2", {if_ready, if_rdata, ramOE}, {1'b1, 16'hA5C3, 1'b1});
    tick(); if_req = 1'b0;

    // Contention: both held high for two accesses each
    tick(); obs_q.delete();
    fork
      begin
        if_addr = 16'h0080; if_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
          wait_rdy(1'b0, "cont_if");
          tick();
          if (k == 0) if_addr = 16'h0081; else if_req = 1'b0;
        end
      end
      begin
        mem_addr = 16'h0100; mem_rd = 1'b1;
        for (int k = 0; k < 2; k++) begin
          wait_rdy(1'b1, "cont_mem");
          tick();
          if (k == 0) mem_addr = 16'h0101; else mem_rd = 1'b0;
        end
      end
    join
    check("cont_count", obs_q.size(), 4);
    for (int i = 0; i < obs_q.size() && i < 4; i++)
      check($sformatf("cont_order%0d", i), obs_q[i], (i % 2 == 0) ? 1 : 0);
    check("cont_if_rdata", if_rdata, 16'h0081 ^ 16'h5A5A);
    check("cont_mem_rdata", mem_rdata, 16'h5B5B);

    // Read and write together: write wins, mem_rdata untouched
    tick(); mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'hBEEF;
    wait_rdy(1'b1, "rw_ready");
    check("rw_rdata_kept", mem_rdata, 16'h5B5B);
    tick(); mem_rd = 1'b0; mem_wr = 1'b0;
    tick(); check("rw_devmem", dev_mem[16'h0200], 16'hBEEF);

    // Reset in the middle of the WE pulse
    tick(); mem_wr = 1'b1; mem_addr = 16'h0300; mem_wdata = 16'h7777;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    check("mid_we_low", ramWE, 1'b0);
    #2 RST = 1'b0; mem_wr = 1'b0;
    #1;
    check("mid_we_rel", ramWE, 1'b1);
    check("mid_bus_rel", ramData, 16'hFFFF);
    check("mid_no_ready", mem_ready, 1'b0);
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b1;
    repeat (4) begin
      @(negedge CLK); check("mid_post_ready", mem_ready, 1'b0);
    end
    check("mid_devmem", dev_mem[16'h0300], 16'h595A);
    tick(); if_req = 1'b1; if_addr = 16'h0300;
    @(negedge CLK); @(negedge CLK);
    @(negedge CLK); check("mid_refetch", {if_ready, if_rdata}, {1'b1, 16'h595A});
    tick(); if_req = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one external 16-bit asynchronous SRAM (RAM2-style OE/WE/EN, 18-bit address, bidirectional data) between the instruction-fetch port and the MEM-stage data port of the pipeline CPU. The block sequences SRAM read and write timing with a small FSM and grants the port with a fairness rule. It returns per-port ready pulses and a stall signal that the hazard logic uses to freeze PC, IF/ID and the downstream pipeline registers.

Parameters:
ADDR_HI, 2'b00, upper two bits of ramAddr, concatenated above the 16-bit request address
WR_PULSE, 1, number of cycles WE is held low during a write (legal range 1..3)

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RST  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ready
if_addr  in  16  fetch address; stable while if_req is high
if_rdata  out  16  fetched word; valid in the if_ready cycle, then holds its value
if_ready  out  1  one-cycle completion pulse for the fetch port
mem_rd  in  1  data read request
mem_wr  in  1  data write request; takes precedence over mem_rd if both are high
mem_addr  in  16  data address
mem_wdata  in  16  write data
mem_rdata  out  16  read data; valid in the mem_ready cycle, then holds its value
mem_ready  out  1  one-cycle completion pulse for the data port
stall  out  1  (if_req & ~if_ready) | ((mem_rd|mem_wr) & ~mem_ready); combinational
ramOE  out  1  SRAM output enable, active-low
ramWE  out  1  SRAM write enable, active-low
ramEN  out  1  SRAM chip enable, active-low
ramAddr  out  18  {ADDR_HI, granted address}
ramData  inout  16  driven only during write states, otherwise high-Z

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, last_grant=IF.
  - ramOE=ramWE=ramEN=1, ramData=Z, ramAddr=0.
  - if_ready=mem_ready=0, if_rdata=mem_rdata=0.
- All SRAM control outputs, ramAddr and the data-drive enable are registered. There are no combinational paths from requests to pins.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE arbitration, on cycle N with a request present:
  - Only the data port requesting: grant data.
  - Only fetch requesting: grant fetch.
  - Both requesting: grant data unless last_grant=MEM, in which case grant fetch. Neither port is starved for more than one access.
  - Latch the granted address, write data and port id, and update last_grant.
- A port whose ready is high in the current cycle is not eligible for grant in that cycle. This prevents a held req from re-triggering.
- Read (fetch, or data with mem_rd only):
  - RD on cycle N+1: ramEN=0, ramOE=0, ramAddr driven.
  - ramData is sampled at the end of N+1.
  - Cycle N+2: state=IDLE, the port's ready=1 and rdata updated.
  - Read latency = 2 cycles from request to ready.
- Write:
  - WR_SETUP: EN=0, OE=1, WE=1, address and data driven.
  - WR_PULSE for WR_PULSE cycles: WE=0.
  - WR_HOLD: WE=1, data still driven.
  - Next cycle: IDLE with mem_ready=1.
  - Latency = 3+WR_PULSE cycles (4 at default).
  - Address and data never change while WE=0.
- Fetch never writes; if_req only ever yields RD.
- A request dropped mid-access does not abort it: the access completes, and the ready pulse is issued and ignored.
- Request inputs are sampled only in IDLE. Address changes mid-access have no effect.
- In IDLE with no grant: EN=OE=WE=1, ramData=Z.
- Reset asserted mid-write forces WE=1 and ramData=Z immediately (asynchronous). The write is lost and no ready pulse is issued.
- ready outputs are never high together; each lasts exactly one cycle.

Decomposition:
- Shared package: state encoding (3-bit localparams), port-id constants GNT_IF/GNT_MEM, and the SRAM idle-level constant.
- One sub-module is natural: sram_tristate_drv (16-bit ramData driver with registered output-enable, plus input capture register).
- Arbitration and the FSM stay in the top module.

Test Plan:
- Reset: hold RST=0 for 3 cycles with if_req=1 -> ramOE/WE/EN=1, ramData=Z, both ready=0, rdata=0; after release, first if_ready appears exactly 2 cycles after the first IDLE sample.
- Fetch read: if_addr=16'h0040, SRAM model word 16'hA5C3 -> ramAddr=18'h00040 with OE=0 for 1 cycle; if_ready=1 and if_rdata=16'hA5C3 two cycles after the request.
- Data write: mem_wr=1, mem_addr=16'h8001, mem_wdata=16'h1234 -> SETUP/PULSE/HOLD observed, WE low exactly 1 cycle with address and data stable; mem_ready 4 cycles after the request; model memory[0x8001]=16'h1234.
- Contention: if_req and mem_rd held high continuously -> grants alternate MEM, IF, MEM, IF; stall stays high until both have completed; no back-to-back double grant to one port.
- Both mem_rd and mem_wr high -> write performed; mem_rdata unchanged.
- Reset mid-write: assert RST during WR_PULSE -> ramWE=1 and ramData=Z in the same cycle; no mem_ready pulse; FSM restarts in IDLE.
